// File: rtl/dht11_pkg.sv
// Shared constants for the DHT11 response packer: command codes, framing bytes,
// sensor-word field offsets and one-hot FSM state encodings.
package dht11_pkg;

  localparam logic [7:0] CMD_HUM    = 8'h01;
  localparam logic [7:0] CMD_TEMP   = 8'h02;
  localparam logic [7:0] CMD_ALL    = 8'h03;
  localparam logic [7:0] CMD_STATUS = 8'h04;

  localparam logic [7:0] HEADER_DEF   = 8'hA5;
  localparam logic [7:0] ERR_CODE_DEF = 8'hEE;

  localparam int unsigned HUM_INT_LSB   = 32;
  localparam int unsigned HUM_FRAC_LSB  = 24;
  localparam int unsigned TEMP_INT_LSB  = 16;
  localparam int unsigned TEMP_FRAC_LSB = 8;

  localparam logic [4:0] ST_IDLE = 5'b00001;
  localparam logic [4:0] ST_HDR  = 5'b00010;
  localparam logic [4:0] ST_CODE = 5'b00100;
  localparam logic [4:0] ST_PAY  = 5'b01000;
  localparam logic [4:0] ST_CSUM = 5'b10000;

  function automatic logic [2:0] payload_len(input logic [7:0] cmd);
    case (cmd)
      CMD_HUM, CMD_TEMP: payload_len = 3'd2;
      CMD_ALL:           payload_len = 3'd4;
      default:           payload_len = 3'd1;
    endcase
  endfunction

  function automatic logic [7:0] field(input logic [39:0] word, input int unsigned lsb);
    field = word[lsb +: 8];
  endfunction

  function automatic logic [7:0] payload_byte(input logic [7:0]  cmd,
                                              input logic [39:0] snap,
                                              input logic [2:0]  idx);
    payload_byte = 8'h00;
    case (cmd)
      CMD_HUM:    payload_byte = (idx == 3'd0) ? field(snap, HUM_INT_LSB)
                                               : field(snap, HUM_FRAC_LSB);
      CMD_TEMP:   payload_byte = (idx == 3'd0) ? field(snap, TEMP_INT_LSB)
                                               : field(snap, TEMP_FRAC_LSB);
      CMD_ALL: begin
        case (idx)
          3'd0:    payload_byte = field(snap, HUM_INT_LSB);
          3'd1:    payload_byte = field(snap, HUM_FRAC_LSB);
          3'd2:    payload_byte = field(snap, TEMP_INT_LSB);
          default: payload_byte = field(snap, TEMP_FRAC_LSB);
        endcase
      end
      // An all-zero snapshot means no reading has been captured yet.
      CMD_STATUS: payload_byte = (snap == 40'd0) ? 8'h01 : 8'h00;
      default:    payload_byte = cmd;
    endcase
  endfunction

endpackage

// File: rtl/dht11_resp_packer.sv
// Accepts a command byte, snapshots the DHT11 word and streams a framed,
// checksummed response (header, code, payload, checksum) over valid/ready.
module dht11_resp_packer
  import dht11_pkg::*;
#(
  parameter logic [7:0]  HEADER     = HEADER_DEF,
  parameter logic [7:0]  ERR_CODE   = ERR_CODE_DEF,
  parameter int unsigned TX_TIMEOUT = 1_000_000
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [39:0] t_h_data,
  input  logic        cmd_valid,
  input  logic [7:0]  cmd_code,
  output logic        cmd_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        timeout_err
);

  localparam int unsigned WAIT_W = (TX_TIMEOUT > 1) ? $clog2(TX_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TX_TIMEOUT - 1);

  logic [4:0]        r_state, w_state_d;
  logic [39:0]       r_snap;
  logic [7:0]        r_cmd, r_csum;
  logic [2:0]        r_idx;
  logic [WAIT_W-1:0] r_wait;
  logic              r_cmd_ready, r_timeout;

  logic       w_accept, w_xfer, w_stall, w_timeout;
  logic [2:0] w_len;
  logic [7:0] w_code;

  assign w_accept  = cmd_valid & r_cmd_ready;
  assign w_xfer    = tx_valid & tx_ready;
  assign w_stall   = tx_valid & ~tx_ready;
  // A transfer on the limit cycle wins because w_stall requires ~tx_ready.
  assign w_timeout = w_stall & (r_wait == WAIT_LIMIT);
  assign w_len     = payload_len(r_cmd);
  assign w_code    = (r_cmd >= CMD_HUM && r_cmd <= CMD_STATUS) ? r_cmd : ERR_CODE;

  assign cmd_ready   = r_cmd_ready;
  assign busy        = (r_state != ST_IDLE);
  assign timeout_err = r_timeout;

  always_comb begin
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    case (r_state)
      ST_HDR:  begin tx_valid = 1'b1; tx_data = HEADER;                             end
      ST_CODE: begin tx_valid = 1'b1; tx_data = w_code;                             end
      ST_PAY:  begin tx_valid = 1'b1; tx_data = payload_byte(r_cmd, r_snap, r_idx); end
      ST_CSUM: begin tx_valid = 1'b1; tx_data = r_csum;                             end
      default: ;
    endcase
  end

  always_comb begin
    w_state_d = r_state;
    if (w_timeout) begin
      w_state_d = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (w_accept) w_state_d = ST_HDR;
        ST_HDR:  if (w_xfer)   w_state_d = ST_CODE;
        ST_CODE: if (w_xfer)   w_state_d = (w_len == 3'd0) ? ST_CSUM : ST_PAY;
        ST_PAY:  if (w_xfer && r_idx == w_len - 3'd1) w_state_d = ST_CSUM;
        ST_CSUM: if (w_xfer)   w_state_d = ST_IDLE;
        default:               w_state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state     <= ST_IDLE;
      r_snap      <= '0;
      r_cmd       <= '0;
      r_csum      <= '0;
      r_idx       <= '0;
      r_wait      <= '0;
      r_cmd_ready <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_cmd_ready <= (w_state_d == ST_IDLE);
      r_timeout   <= w_timeout;

      if (w_accept) begin
        r_snap <= t_h_data;
        r_cmd  <= cmd_code;
        r_csum <= '0;
      end else if (w_xfer && (r_state == ST_CODE || r_state == ST_PAY)) begin
        r_csum <= r_csum + tx_data;
      end

      if (w_xfer && r_state == ST_HDR) begin
        r_idx <= '0;
      end else if (w_xfer && r_state == ST_PAY) begin
        r_idx <= r_idx + 3'd1;
      end

      if (w_accept || w_xfer || w_timeout) begin
        r_wait <= '0;
      end else if (w_stall) begin
        r_wait <= r_wait + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dht11_resp_packer.sv
// Directed bench for dht11_resp_packer: table of full frames plus hand-written
// backpressure, timeout and mid-frame reset sequences.
module tb_dht11_resp_packer;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic [39:0] t_h_data;
  logic        cmd_valid;
  logic [7:0]  cmd_code;
  logic        cmd_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic        timeout_err;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [7:0]  cmd;
    logic [39:0] data;
    int          n;
    logic [55:0] bytes;  // first byte in the MSBs
    bit          chg;    // corrupt t_h_data after the header
  } vec_t;

  vec_t vecs[$];

  localparam logic [39:0] DATA = 40'h37001A0556;

  dht11_resp_packer #(
    .HEADER    (8'hA5),
    .ERR_CODE  (8'hEE),
    .TX_TIMEOUT(16)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .t_h_data   (t_h_data),
    .cmd_valid  (cmd_valid),
    .cmd_code   (cmd_code),
    .cmd_ready  (cmd_ready),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .busy       (busy),
    .timeout_err(timeout_err)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_ready();
    int k = 0;
    while (cmd_ready !== 1'b1 && k < 50) begin
      @(negedge sys_clk);
      k++;
    end
    check("cmd_ready_wait", {39'd0, cmd_ready}, 40'd1);
  endtask

  task automatic run_frame(input vec_t v, input string tag);
    wait_ready();
    tx_ready  = 1'b1;
    t_h_data  = v.data;
    cmd_code  = v.cmd;
    cmd_valid = 1'b1;
    for (int i = 0; i < v.n; i++) begin
      @(negedge sys_clk);
      cmd_valid = 1'b0;
      check($sformatf("%s valid[%0d]", tag, i), {39'd0, tx_valid}, 40'd1);
      check($sformatf("%s data[%0d]", tag, i), {32'd0, tx_data}, {32'd0, v.bytes[55-8*i -: 8]});
      check($sformatf("%s cmd_ready[%0d]", tag, i), {39'd0, cmd_ready}, 40'd0);
      if (i == 0 && v.chg) t_h_data = 40'hFFFFFFFFFF;
    end
    @(negedge sys_clk);
    check($sformatf("%s end valid", tag), {39'd0, tx_valid}, 40'd0);
    check($sformatf("%s end cmd_ready", tag), {39'd0, cmd_ready}, 40'd1);
    t_h_data = DATA;
  endtask

  initial begin
    vec_t v;
    vecs.push_back('{8'h02, DATA,          5, 56'hA5_02_1A_05_21_00_00, 1'b0});
    vecs.push_back('{8'h03, DATA,          7, 56'hA5_03_37_00_1A_05_59, 1'b1});
    vecs.push_back('{8'h7F, DATA,          4, 56'hA5_EE_7F_6D_00_00_00, 1'b0});
    vecs.push_back('{8'h04, 40'd0,         4, 56'hA5_04_01_05_00_00_00, 1'b0});
    vecs.push_back('{8'h04, DATA,          4, 56'hA5_04_00_04_00_00_00, 1'b0});
    vecs.push_back('{8'h01, DATA,          5, 56'hA5_01_37_00_38_00_00, 1'b0});
    vecs.push_back('{8'h00, DATA,          4, 56'hA5_EE_00_EE_00_00_00, 1'b0});
    vecs.push_back('{8'h03, 40'hFFFFFFFF00, 7, 56'hA5_03_FF_FF_FF_FF_FF, 1'b0});
    vecs.push_back('{8'hFF, 40'd0,         4, 56'hA5_EE_FF_ED_00_00_00, 1'b0});

    sys_rst_n = 1'b0;
    t_h_data  = DATA;
    cmd_valid = 1'b0;
    cmd_code  = 8'h00;
    tx_ready  = 1'b1;
    #12;
    check("rst cmd_ready", {39'd0, cmd_ready}, 40'd0);
    check("rst tx_valid", {39'd0, tx_valid}, 40'd0);
    check("rst tx_data", {32'd0, tx_data}, 40'd0);
    check("rst busy", {39'd0, busy}, 40'd0);
    check("rst timeout_err", {39'd0, timeout_err}, 40'd0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    check("post-rst cmd_ready", {39'd0, cmd_ready}, 40'd1);

    foreach (vecs[k]) run_frame(vecs[k], $sformatf("vec%0d", k));

    // Backpressure before the third byte, with a command held while busy.
    wait_ready();
    cmd_code = 8'h02; cmd_valid = 1'b1; tx_ready = 1'b1;
    @(negedge sys_clk);
    cmd_valid = 1'b0;
    check("bp hdr", {32'd0, tx_data}, 40'hA5);
    @(negedge sys_clk);
    check("bp code", {32'd0, tx_data}, 40'h02);
    @(negedge sys_clk);
    check("bp pay0", {32'd0, tx_data}, 40'h1A);
    tx_ready = 1'b0; cmd_code = 8'h01; cmd_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge sys_clk);
      check("bp hold valid", {39'd0, tx_valid}, 40'd1);
      check("bp hold data", {32'd0, tx_data}, 40'h1A);
      check("bp hold cmd_ready", {39'd0, cmd_ready}, 40'd0);
      check("bp hold timeout", {39'd0, timeout_err}, 40'd0);
    end
    tx_ready = 1'b1;
    @(negedge sys_clk);
    check("bp pay1", {32'd0, tx_data}, 40'h05);
    @(negedge sys_clk);
    check("bp csum", {32'd0, tx_data}, 40'h21);
    @(negedge sys_clk);
    check("bp idle valid", {39'd0, tx_valid}, 40'd0);
    check("bp idle cmd_ready", {39'd0, cmd_ready}, 40'd1);
    @(negedge sys_clk);
    cmd_valid = 1'b0;
    check("bp held hdr", {32'd0, tx_data}, 40'hA5);
    @(negedge sys_clk);
    check("bp held code", {32'd0, tx_data}, 40'h01);
    @(negedge sys_clk);
    check("bp held p0", {32'd0, tx_data}, 40'h37);
    @(negedge sys_clk);
    check("bp held p1", {32'd0, tx_data}, 40'h00);
    @(negedge sys_clk);
    check("bp held csum", {32'd0, tx_data}, 40'h38);
    @(negedge sys_clk);
    check("bp held end", {39'd0, tx_valid}, 40'd0);

    // Timeout: stuck after the header, 16 waiting cycles then abort.
    wait_ready();
    cmd_code = 8'h01; cmd_valid = 1'b1; tx_ready = 1'b1;
    @(negedge sys_clk);
    cmd_valid = 1'b0;
    @(negedge sys_clk);
    check("to code", {32'd0, tx_data}, 40'h01);
    tx_ready = 1'b0;
    for (int i = 1; i < 16; i++) begin
      @(negedge sys_clk);
      check($sformatf("to wait valid %0d", i), {39'd0, tx_valid}, 40'd1);
      check($sformatf("to wait err %0d", i), {39'd0, timeout_err}, 40'd0);
    end
    @(negedge sys_clk);
    check("to abort valid", {39'd0, tx_valid}, 40'd0);
    check("to abort err", {39'd0, timeout_err}, 40'd1);
    check("to abort cmd_ready", {39'd0, cmd_ready}, 40'd1);
    tx_ready = 1'b1;
    @(negedge sys_clk);
    check("to err pulse", {39'd0, timeout_err}, 40'd0);
    check("to quiet valid", {39'd0, tx_valid}, 40'd0);
    run_frame(vecs[0], "after_to");

    // tx_ready rising on the limit cycle: transfer wins.
    wait_ready();
    cmd_code = 8'h01; cmd_valid = 1'b1; tx_ready = 1'b1;
    @(negedge sys_clk);
    cmd_valid = 1'b0;
    @(negedge sys_clk);
    tx_ready = 1'b0;
    for (int i = 1; i < 16; i++) @(negedge sys_clk);
    tx_ready = 1'b1;
    @(negedge sys_clk);
    check("edge valid", {39'd0, tx_valid}, 40'd1);
    check("edge err", {39'd0, timeout_err}, 40'd0);
    check("edge p0", {32'd0, tx_data}, 40'h37);
    @(negedge sys_clk);
    check("edge p1", {32'd0, tx_data}, 40'h00);
    @(negedge sys_clk);
    check("edge csum", {32'd0, tx_data}, 40'h38);

    // Reset during payload.
    wait_ready();
    cmd_code = 8'h03; cmd_valid = 1'b1;
    @(negedge sys_clk);
    cmd_valid = 1'b0;
    @(negedge sys_clk);
    @(negedge sys_clk);
    check("mr pay", {32'd0, tx_data}, 40'h37);
    sys_rst_n = 1'b0;
    #1;
    check("mr tx_valid", {39'd0, tx_valid}, 40'd0);
    check("mr tx_data", {32'd0, tx_data}, 40'd0);
    check("mr busy", {39'd0, busy}, 40'd0);
    check("mr cmd_ready", {39'd0, cmd_ready}, 40'd0);
    check("mr timeout_err", {39'd0, timeout_err}, 40'd0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    check("mr post cmd_ready", {39'd0, cmd_ready}, 40'd1);
    v = vecs[5];
    run_frame(v, "after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/dht11_resp_packer.md
Name: dht11_resp_packer

Overview:
- Downstream consumer of the DHT11 controller's validated 40-bit temperature/humidity word (t_h_data).
- On a command byte from the UART receive path, it snapshots that word and emits a framed, checksummed byte response to the UART transmit path.
- The UART transmit path is driven over a valid/ready handshake.
- It sits between dht11_control and the UART TX on the FPGA side of the I/O interface.

Parameters:
- HEADER, 8'hA5, first byte of every response frame.
- ERR_CODE, 8'hEE, response code for an unknown command.
- TX_TIMEOUT, 1_000_000, maximum cycles to wait for tx_ready on any one byte before aborting the frame.

Ports:
- sys_clk  input  1  system clock; one clock domain.
- sys_rst_n  input  1  asynchronous active-low reset.
- t_h_data  input  40  sensor word: [39:32] hum int, [31:24] hum frac, [23:16] temp int, [15:8] temp frac, [7:0] sensor checksum (ignored).
- cmd_valid  input  1  command byte available.
- cmd_code  input  8  command byte.
- cmd_ready  output  1  block accepts a command.
- tx_data  output  8  response byte.
- tx_valid  output  1  tx_data valid.
- tx_ready  input  1  UART TX accepts the byte.
- busy  output  1  a frame is in progress.
- timeout_err  output  1  one-cycle pulse when a frame is aborted.

Behaviour:
- Reset values: cmd_ready=0, tx_data=0, tx_valid=0, busy=0, timeout_err=0, state=IDLE, snapshot=0. Reset mid-frame abandons the frame immediately; no partial resume.
- States: IDLE, HDR, CODE, PAY, CSUM.
  - IDLE: cmd_ready=1, busy=0. A command is accepted on a cycle with cmd_valid&cmd_ready.
  - On accept: snapshot<=t_h_data, cmd register<=cmd_code, next state HDR.
  - HDR: tx_valid=1, tx_data=HEADER. This is asserted the cycle after accept (1-cycle latency).
  - HDR->CODE->PAY (or CSUM if payload length is 0)->CSUM->IDLE. Each transition happens only on a cycle with tx_valid&tx_ready.
  - A byte transfers on the cycle tx_valid&tx_ready is high. The next byte is presented on the following cycle, so tx_valid stays high and back-to-back transfers are allowed.
  - After the CSUM transfer: tx_valid=0, IDLE, cmd_ready=1 on the next cycle.
- Handshake rules:
  - While tx_valid=1 and tx_ready=0, tx_data is held stable.
  - cmd_ready=0 in every non-IDLE state. A cmd_valid arriving while busy is not consumed; the source holds it.
- Response code and payload, using the snapshot, sent in the order listed:
  - 0x01: code 0x01, payload hum int, hum frac (2 bytes).
  - 0x02: code 0x02, payload temp int, temp frac (2 bytes).
  - 0x03: code 0x03, payload hum int, hum frac, temp int, temp frac (4 bytes).
  - 0x04: code 0x04, payload 1 byte: 0x01 if snapshot==0 (no valid reading yet), else 0x00.
  - Any other code: code ERR_CODE, payload 1 byte = received cmd_code.
- Checksum byte:
  - Sum mod 256 of the code byte and all payload bytes; the header is excluded.
  - Accumulated in an 8-bit register, wrap-around intended.
- Payload index: 3-bit counter from 0 to len-1, cleared on entry to CODE.
- Snapshot coherence: changes to t_h_data during a frame do not affect that frame.
- Timeout:
  - A wait counter clears on every transfer and on frame start, and counts while tx_valid&~tx_ready.
  - When it reaches TX_TIMEOUT-1: tx_valid<=0, state<=IDLE, timeout_err pulses for 1 cycle, no further bytes of that frame are sent.
  - If tx_ready rises on the same cycle the limit is reached, the transfer wins and there is no timeout.

Decomposition:
- Package dht11_pkg holds:
  - Command codes (CMD_HUM=8'h01, CMD_TEMP=8'h02, CMD_ALL=8'h03, CMD_STATUS=8'h04).
  - HEADER and ERR_CODE defaults.
  - Field bit offsets of t_h_data.
  - One-hot state encoding localparams.
- Sub-module: none. The payload byte mux and checksum accumulator stay inline; the block is a single FSM with counters.

Test Plan:
- Temp read: t_h_data=40'h37001A0556, tx_ready=1, cmd 0x02 -> tx bytes A5 02 1A 05 21 on consecutive cycles, header the cycle after accept; cmd_ready=0 throughout.
- All read: same data, cmd 0x03 -> A5 03 37 00 1A 05 59. Change t_h_data to 40'hFFFFFFFFFF after the header is sent -> remaining bytes unchanged.
- Unknown command 0x7F -> A5 EE 7F 6D. Status command with t_h_data=0 -> A5 04 01 05.
- Backpressure: hold tx_ready=0 for 10 cycles before the third byte -> tx_valid=1 and tx_data=1A stable throughout, frame completes intact. A cmd_valid held during this period is accepted only after return to IDLE.
- Timeout: TX_TIMEOUT=16, tx_ready stuck 0 after the header -> tx_valid falls and timeout_err pulses exactly once after 16 waiting cycles. The next command produces a complete fresh frame.
- Reset mid-frame: assert sys_rst_n=0 during PAY -> all outputs 0 asynchronously. After release, cmd_ready=1 and a new cmd 0x01 yields A5 01 37 00 38.
